// File: rtl/result_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : result_wb_buffer
// Brief    : FIFO write-back buffer from the SIMD result port to the result RAM,
//            with valid/ready drain and a stop-to-done tracker.
//            Optional in-place tail coalescing: RESULT_WB_COALESCE_EN
// Revision : 1.0 - initial release
// ============================================================================
module result_wb_buffer #(
   parameter int DATA_WIDTH      = 32,
   parameter int PE_ELEMENTS     = 4,
   parameter int DRAM_ADDR_WIDTH = 8,
   parameter int FIFO_DEPTH      = 4,
   parameter int CNT_WIDTH       = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                                   clk,
   input  logic                                   rstn,
   input  logic                                   in_wr_en,
   input  logic [DRAM_ADDR_WIDTH-1:0]             in_addr,
   input  logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0] in_data,
   input  logic                                   proc_stop,
   output logic                                   mem_wr_en,
   output logic [DRAM_ADDR_WIDTH-1:0]             mem_addr,
   output logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0] mem_data,
   input  logic                                   mem_ready,
   output logic [CNT_WIDTH-1:0]                   count,
   output logic                                   overflow,
   output logic                                   done
);

   localparam int                   PTR_WIDTH = $clog2(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] ONE_CNT   = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                                   state_q, state_d;
   logic [PTR_WIDTH-1:0]                     rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH-1:0]                     wr_ptr_q, wr_ptr_d;
   logic [CNT_WIDTH-1:0]                     count_q, count_d;
   logic                                     overflow_q, overflow_d;
   logic [DRAM_ADDR_WIDTH-1:0]               addr_q [FIFO_DEPTH];
   logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0]   data_q [FIFO_DEPTH];

   logic                  empty, full, accept, pop, push, drop, coal_hit, drain_ok;
   logic [FIFO_DEPTH-1:0] coal_sel, wen;

   assign empty  = (count_q == '0);
   assign full   = (count_q == FULL_CNT);
   assign accept = in_wr_en && (state_q != ST_DONE);
   assign pop    = !empty && mem_ready;

`ifdef RESULT_WB_COALESCE_EN
   logic [PTR_WIDTH-1:0] tail_ptr;
   assign tail_ptr = wr_ptr_q - 1'b1;
   // A lone entry leaving this cycle cannot absorb the write; it must re-allocate.
   assign coal_hit = accept && !empty && (addr_q[tail_ptr] == in_addr)
                     && !((count_q == ONE_CNT) && pop);
   always_comb begin
      coal_sel = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         coal_sel[i] = coal_hit && (tail_ptr == PTR_WIDTH'(i));
      end
   end
`else
   assign coal_hit = 1'b0;
   assign coal_sel = '0;
`endif

   assign push = accept && !coal_hit && (!full || pop);
   assign drop = accept && !coal_hit && full && !pop;

   always_comb begin
      wen = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         wen[i] = (push && (wr_ptr_q == PTR_WIDTH'(i))) || coal_sel[i];
      end
   end

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q || drop;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // Empty after this edge with nothing arriving: all results committed.
   assign drain_ok = !in_wr_en && (empty || ((count_q == ONE_CNT) && pop));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (proc_stop) begin
               state_d = drain_ok ? ST_DONE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drain_ok) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_DONE;
         default:  state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_RUN;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is cleared on reset so the head view reads zero afterwards.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (wen[i]) begin
               addr_q[i] <= in_addr;
               data_q[i] <= in_data;
            end
         end
      end
   end

   assign mem_wr_en = !empty;
   assign mem_addr  = addr_q[rd_ptr_q];
   assign mem_data  = data_q[rd_ptr_q];
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign done      = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_result_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_wb_buffer
// Brief    : Directed plus randomized bench for result_wb_buffer against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_wb_buffer;

   localparam int DW    = 32;
   localparam int PE    = 4;
   localparam int AW    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   typedef logic [PE-1:0][DW-1:0] vec_t;
   typedef struct packed {
      logic [AW-1:0] a;
      vec_t          d;
   } ent_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          in_wr_en = 1'b0;
   logic [AW-1:0] in_addr = '0;
   vec_t          in_data = '0;
   logic          proc_stop = 1'b0;
   logic          mem_ready = 1'b0;
   logic          mem_wr_en;
   logic [AW-1:0] mem_addr;
   vec_t          mem_data;
   logic [CW-1:0] count;
   logic          overflow;
   logic          done;

   ent_t q[$];
   bit   m_ovf, m_stop, m_done;
   int   n_vec = 0;
   int   n_bad = 0;

   result_wb_buffer #(
      .DATA_WIDTH(DW), .PE_ELEMENTS(PE), .DRAM_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rstn(rstn), .in_wr_en(in_wr_en), .in_addr(in_addr), .in_data(in_data),
      .proc_stop(proc_stop), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_ready(mem_ready), .count(count), .overflow(overflow), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic vec_t mk(input int a, input int b, input int c, input int d);
      vec_t v;
      v[0] = DW'(a); v[1] = DW'(b); v[2] = DW'(c); v[3] = DW'(d);
      return v;
   endfunction

   task automatic do_reset();
      in_wr_en = 1'b0; proc_stop = 1'b0; mem_ready = 1'b0;
      rstn = 1'b0;
      #1;
      chk("rst_mem_wr_en", 128'(mem_wr_en), 128'(0));
      chk("rst_mem_addr",  128'(mem_addr),  128'(0));
      chk("rst_mem_data",  128'(mem_data),  128'(0));
      chk("rst_count",     128'(count),     128'(0));
      chk("rst_overflow",  128'(overflow),  128'(0));
      chk("rst_done",      128'(done),      128'(0));
      q.delete(); m_ovf = 0; m_stop = 0; m_done = 0;
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One clock: drive, check outputs against the model, advance the model.
   task automatic step(input bit wr, input logic [AW-1:0] a, input vec_t d,
                       input bit stop, input bit rdy);
      bit   popped, coal, push;
      int   sz;
      ent_t e;
      in_wr_en = wr; in_addr = a; in_data = d; proc_stop = stop; mem_ready = rdy;
      @(negedge clk);
      sz = q.size();
      chk("mem_wr_en", 128'(mem_wr_en), 128'(sz != 0));
      chk("count",     128'(count),     128'(sz));
      chk("overflow",  128'(overflow),  128'(m_ovf));
      chk("done",      128'(done),      128'(m_done));
      if (sz != 0) begin
         chk("mem_addr", 128'(mem_addr), 128'(q[0].a));
         chk("mem_data", 128'(mem_data), 128'(q[0].d));
      end
      popped = (sz != 0) && rdy;
      coal   = 0;
      push   = 0;
      if (wr && !m_done) begin
`ifdef RESULT_WB_COALESCE_EN
         coal = (sz != 0) && (q[sz-1].a == a) && !(sz == 1 && popped);
`endif
         if (!coal) begin
            if (sz < DEPTH || popped) push = 1;
            else                      m_ovf = 1;
         end
      end
      if (popped) void'(q.pop_front());
      if (coal) q[q.size()-1].d = d;
      if (push) begin
         e.a = a; e.d = d;
         q.push_back(e);
      end
      if (!m_done && (m_stop || stop) && q.size() == 0 && !wr) m_done = 1;
      if (stop) m_stop = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit rdy, input int n);
      for (int i = 0; i < n; i++) step(0, '0, '0, 0, rdy);
   endtask

   initial begin
      do_reset();

      // Single write, one-cycle latency, immediate drain
      step(1, 8'h10, mk(1, 2, 3, 4), 0, 1);
      idle(1, 2);

      // Fill, overflow, ordered drain
      for (int i = 0; i < 4; i++) step(1, AW'(i), mk(i, i, i, i), 0, 0);
      step(1, 8'h04, mk(4, 4, 4, 4), 0, 0);
      idle(0, 1);
      idle(1, 5);

      // Full with simultaneous push and pop
      do_reset();
      for (int i = 0; i < 4; i++) step(1, AW'(8'h30 + i), mk(i, 7, 7, i), 0, 0);
      step(1, 8'h20, mk(8, 8, 8, 8), 0, 1);
      idle(1, 5);

      // Stop with pending entries, done after final pop, writes ignored after
      do_reset();
      step(1, 8'h41, mk(1, 0, 0, 1), 0, 0);
      step(1, 8'h42, mk(2, 0, 0, 2), 0, 0);
      step(0, '0, '0, 1, 0);
      idle(0, 2);
      idle(1, 3);
      step(1, 8'h43, mk(3, 0, 0, 3), 0, 0);
      idle(1, 2);

      // Same-address back-to-back writes
      do_reset();
      step(1, 8'h05, mk(1, 1, 1, 1), 0, 0);
      step(1, 8'h05, mk(9, 9, 9, 9), 0, 0);
      idle(0, 1);
      idle(1, 3);

      // Reset while entries are buffered
      do_reset();
      for (int i = 0; i < 3; i++) step(1, AW'(8'h50 + i), mk(5, i, 5, i), 0, 0);
      do_reset();
      idle(0, 3);
      idle(1, 2);

      // Randomized traffic, stop near the end of each round
      for (int r = 0; r < 6; r++) begin
         do_reset();
         for (int c = 0; c < 150; c++) begin
            bit rdy;
            rdy = (r % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            step(bit'($urandom_range(0, 1)), AW'($urandom_range(0, 3)),
                 {$urandom, $urandom, $urandom, $urandom},
                 (c > 110) && ($urandom_range(0, 7) == 0), rdy);
         end
         idle(1, 6);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/result_wb_buffer.md
# result_wb_buffer

Write-back buffer between the SIMD processor's result port and the result vector RAM. Every single-cycle write pulse from the processor (`ram_result_wr_en` with address and `PE_ELEMENTS`-lane data) is captured into a small FIFO. The FIFO drains to a memory write port under a valid/ready handshake, so a slow or arbitrated result RAM cannot drop results. The block also turns the processor's `stop` into a `done` flag that asserts only once every buffered result has been committed.

## Interface

**Parameters**
- `DATA_WIDTH`, default 32: width of one PE lane.
- `PE_ELEMENTS`, default 4: number of lanes per vector word.
- `DRAM_ADDR_WIDTH`, default 8: result RAM address width.
- `FIFO_DEPTH`, default 4: buffer entries. Must be a power of two, ≥2.
- `CNT_WIDTH`, default `$clog2(FIFO_DEPTH+1)`: width of the occupancy count.

**Ports**
- `clk`, input, 1: single clock. All state is on the rising edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `in_wr_en`, input, 1: processor result write strobe.
- `in_addr`, input, `DRAM_ADDR_WIDTH`: processor result address.
- `in_data`, input, `[PE_ELEMENTS-1:0][DATA_WIDTH-1:0]`: processor result vector.
- `proc_stop`, input, 1: processor `stop`. Level or pulse.
- `mem_wr_en`, output, 1: write valid toward the result RAM.
- `mem_addr`, output, `DRAM_ADDR_WIDTH`: head entry address.
- `mem_data`, output, `[PE_ELEMENTS-1:0][DATA_WIDTH-1:0]`: head entry data.
- `mem_ready`, input, 1: the RAM accepts the current write this cycle.
- `count`, output, `CNT_WIDTH`: occupied entries.
- `overflow`, output, 1: sticky. A write was dropped.
- `done`, output, 1: sticky. Stop has been seen and all results are committed.

## Operation

- **Storage:** circular FIFO with `FIFO_DEPTH` entries of {addr, data}. Read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo `FIFO_DEPTH`. Full and empty are derived from `count`.
- **Push:** occurs on `in_wr_en` when not full, or when full and a pop happens in the same cycle.
- **Pop:** occurs when `mem_wr_en && mem_ready`.
- **Output drive:**
  - `mem_wr_en = (count != 0)`.
  - `mem_addr` and `mem_data` always show the head entry.
  - These outputs are driven only from registers (no combinational path from `in_*`).
- **Overflow:** `in_wr_en` while full with no pop drops the write, leaves the FIFO contents unchanged, and sets `overflow`. `overflow` clears only on reset.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance. This holds at every occupancy, including empty→1→0 sequences.
- **State machine:** three states, RUN, DRAIN, DONE.
  - RUN → DRAIN when `proc_stop` = 1.
  - In DRAIN, pushes are still accepted, to cover a final result coincident with or after `stop`.
  - DRAIN → DONE when `count == 0` and `in_wr_en == 0`.
  - DONE is terminal until reset. In DONE, `in_wr_en` is ignored and sets no flags. `done = (state == DONE)`.
  - RUN → DONE directly when `proc_stop && count == 0 && !in_wr_en`.
- **Reset mid-operation:** asserting `rstn` low asynchronously discards all buffered entries. Partially drained data is lost by design.

## Timing

- **Reset values:** `mem_wr_en` 0, `mem_addr` 0, `mem_data` 0, `count` 0, `overflow` 0, `done` 0, state RUN, both pointers 0.
- **Latency:** a push in cycle N into an empty FIFO gives `mem_wr_en` = 1 with that entry in cycle N+1. The minimum in→mem latency is one cycle.
- **Stable outputs:** while `mem_wr_en && !mem_ready`, `mem_addr` and `mem_data` hold stable.
- **Throughput:** one entry per cycle when `mem_ready` is held high. With `mem_ready` high and `in_wr_en` every cycle, `count` never exceeds 1.
- **Done timing:** `done` rises in the cycle after the final pop, or in the cycle after `proc_stop` if the FIFO is already empty.

## Configuration

- **Macro:** `RESULT_WB_COALESCE_EN`.
- **Defined:**
  - A push whose `in_addr` equals the address of the newest (tail) entry overwrites that entry's data in place instead of allocating a new entry. `count` is unchanged.
  - Coalescing is suppressed when the tail entry is also the head and is being popped in that cycle. In that case a normal push occurs.
  - A coalescing write when full does not set `overflow`.
- **Undefined:** every accepted write allocates a new entry, and the coalescing comparator is absent.

## Test plan

- Reset, then write addr 0x10, data {1,2,3,4}, with `mem_ready` = 1 → `mem_wr_en` is high in the next cycle with 0x10/{1,2,3,4}, and `count` returns to 0.
- `mem_ready` = 0; 4 writes to addr 0..3, then a 5th to addr 4 → `count` = 4, `overflow` = 1. Then `mem_ready` = 1 → addresses 0,1,2,3 drain in order, and addr 4 never appears.
- Full FIFO; `in_wr_en` and `mem_ready` both high in the same cycle → `count` stays 4, `overflow` stays 0, and the new entry emerges after the three older ones.
- `mem_ready` = 0 with 2 entries; pulse `proc_stop` → `done` = 0. Release `mem_ready` → `done` = 1 the cycle after the second pop. A subsequent `in_wr_en` has no effect.
- With `RESULT_WB_COALESCE_EN` defined, `mem_ready` = 0: write addr 5 {1,1,1,1}, then addr 5 {9,9,9,9} → `count` = 1, and the drained data is {9,9,9,9}. Without the macro → `count` = 2, and both entries drain in order.
- Assert `rstn` low while 3 entries are buffered → all outputs are 0 immediately. After release, `mem_wr_en` stays 0 until a new write.
